fetch_control_unit: RTL and testbench

- Upstream neighbour of the datapath.
- Fetches 8-bit instructions from a synchronous-read instruction memory using a program counter, and latches them into an instruction register.
- Decodes each instruction and drives opcode, operand, alu_ctrl, reg_we and mem_we into the datapath.
- Multi-cycle FSM, one instruction at a time; handles JMP and HALT locally.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/instr_decoder.sv | 35 +++
 rtl/fetch_control_unit.sv | 100 ++++++++++
 tb/tb_fetch_control_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, ALU select codes, fetch FSM state encoding.
// Pure declarations, no latency.
// No flow control involved.
package cpu_pkg;

    localparam int INSTR_W = 8;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXECUTE = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

endpackage

// File: rtl/instr_decoder.sv
// Opcode decoder: ALU select plus ungated write strobes and jump/halt flags.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the raw strobes.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [2:0] o_alu_ctrl,
    output logic       o_reg_we_raw,
    output logic       o_mem_we_raw,
    output logic       o_is_jmp,
    output logic       o_is_halt
);

    always_comb begin
        o_alu_ctrl   = ALU_ADD;
        o_reg_we_raw = 1'b0;
        o_mem_we_raw = 1'b0;
        o_is_jmp     = 1'b0;
        o_is_halt    = 1'b0;
        case (i_opcode)
            OP_LOAD:  o_reg_we_raw = 1'b1;
            OP_STORE: o_mem_we_raw = 1'b1;
            OP_ADD:   begin o_alu_ctrl = ALU_ADD; o_reg_we_raw = 1'b1; end
            OP_SUB:   begin o_alu_ctrl = ALU_SUB; o_reg_we_raw = 1'b1; end
            OP_AND:   begin o_alu_ctrl = ALU_AND; o_reg_we_raw = 1'b1; end
            OP_OR:    begin o_alu_ctrl = ALU_OR;  o_reg_we_raw = 1'b1; end
            OP_XOR:   begin o_alu_ctrl = ALU_XOR; o_reg_we_raw = 1'b1; end
            OP_JMP:   o_is_jmp  = 1'b1;
            OP_HALT:  o_is_halt = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/fetch_control_unit.sv
// Fetch/decode/execute control FSM; optional retired-instruction counter under FETCH_CTRL_INSTR_COUNT_EN.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE); strobes valid only in EXECUTE.
// No backpressure: run is a level enable sampled in IDLE and at the end of EXECUTE.
module fetch_control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = 4,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         opcode,
    output logic [3:0]         operand,
    output logic [2:0]         alu_ctrl,
    output logic               reg_we,
    output logic               mem_we,
    output logic [PC_W-1:0]    pc,
    output logic               halted
`ifdef FETCH_CTRL_INSTR_COUNT_EN
    ,
    output logic [7:0]         instr_count
`endif
);

    logic [2:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;

    logic               w_exec;
    logic               w_reg_we_raw;
    logic               w_mem_we_raw;
    logic               w_is_jmp;
    logic               w_is_halt;
    logic [PC_W-1:0]    w_jmp_tgt;

    assign opcode    = r_ir[INSTR_W-1 -: 4];
    assign operand   = r_ir[3:0];
    assign w_jmp_tgt = PC_W'(operand);
    assign w_exec    = (r_state == ST_EXECUTE);

    instr_decoder u_dec (
        .i_opcode     (opcode),
        .o_alu_ctrl   (alu_ctrl),
        .o_reg_we_raw (w_reg_we_raw),
        .o_mem_we_raw (w_mem_we_raw),
        .o_is_jmp     (w_is_jmp),
        .o_is_halt    (w_is_halt)
    );

    // Strobes are combinational from state, so an async reset drops them at once.
    assign reg_we    = w_exec & w_reg_we_raw;
    assign mem_we    = w_exec & w_mem_we_raw;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign halted    = (r_state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) r_state <= ST_FETCH;
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_ir    <= imem_data;
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    r_pc <= w_is_jmp ? w_jmp_tgt : r_pc + PC_W'(1);
                    if (w_is_halt)  r_state <= ST_HALT;
                    else if (run)   r_state <= ST_FETCH;
                    else            r_state <= ST_IDLE;
                end
                ST_HALT: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_CTRL_INSTR_COUNT_EN
    logic [7:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_instr_cnt <= 8'h00;
        else if (w_exec && r_instr_cnt != 8'hFF)
            r_instr_cnt <= r_instr_cnt + 8'h01;
    end

    assign instr_count = r_instr_cnt;
`endif

endmodule

// File: tb/tb_fetch_control_unit.sv
// Bench for fetch_control_unit: directed scenarios plus random programs/run patterns
// against an instruction-level reference model.
module tb_fetch_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] imem_addr;
    logic [7:0] imem_data = 8'h00;
    logic [3:0] opcode, operand, pc;
    logic [2:0] alu_ctrl;
    logic       reg_we, mem_we, halted;
`ifdef FETCH_CTRL_INSTR_COUNT_EN
    logic [7:0] instr_count;
`endif

    logic [7:0] mem [16];

    int n_err = 0;
    int n_chk = 0;

    // Reference model: where we are inside an instruction, in plain terms.
    int         m_mode;   // 0 idle, 1 running an instruction, 2 halted
    int         m_step;   // 0 fetch, 1 decode, 2 execute
    logic [3:0] m_pc;
    logic [7:0] m_ir;
    int         m_count;

    logic saw3, saw_wrap;
    logic [3:0] prev_pc;

    fetch_control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .opcode    (opcode),
        .operand   (operand),
        .alu_ctrl  (alu_ctrl),
        .reg_we    (reg_we),
        .mem_we    (mem_we),
        .pc        (pc),
        .halted    (halted)
`ifdef FETCH_CTRL_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    function automatic logic [2:0] exp_alu(input logic [3:0] op);
        case (op)
            4'h3:    return 3'b001;
            4'h4:    return 3'b010;
            4'h5:    return 3'b011;
            4'h6:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic exp_reg(input logic [3:0] op);
        return (op == 4'h0) || (op >= 4'h2 && op <= 4'h6);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_pc = 4'h0; m_ir = 8'h00; m_count = 0;
    endtask

    task automatic model_step(input logic r);
        if (!rst_n) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (r) begin m_mode = 1; m_step = 0; end
        end else if (m_mode == 1) begin
            if (m_step == 0) m_step = 1;
            else if (m_step == 1) begin m_ir = mem[m_pc]; m_step = 2; end
            else begin
                if (m_count < 255) m_count++;
                m_pc = (m_ir[7:4] == 4'h7) ? m_ir[3:0] : 4'((m_pc + 1) % 16);
                if (m_ir[7:4] == 4'hF) m_mode = 2;
                else if (r) m_step = 0;
                else m_mode = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic ex;
        ex = (m_mode == 1) && (m_step == 2);
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("opcode", opcode, m_ir[7:4]);
        chk("operand", operand, m_ir[3:0]);
        chk("reg_we", reg_we, ex && exp_reg(m_ir[7:4]));
        chk("mem_we", mem_we, ex && (m_ir[7:4] == 4'h1));
        chk("we_exclusive", reg_we & mem_we, 1'b0);
        if (ex) chk("alu_ctrl", alu_ctrl, exp_alu(m_ir[7:4]));
        chk("halted", halted, m_mode == 2);
`ifdef FETCH_CTRL_INSTR_COUNT_EN
        chk("instr_count", instr_count, m_count);
`endif
    endtask

    task automatic tick();
        logic r;
        r = run;
        @(posedge clk);
        model_step(r);
        #1;
        check_outputs();
        if (imem_addr == 4'h3) saw3 = 1'b1;
        if (prev_pc == 4'hF && pc == 4'h0) saw_wrap = 1'b1;
        prev_pc = pc;
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("reset_alu_ctrl", alu_ctrl, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic run_until_halt(input int budget);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < budget) begin tick(); n++; end
        chk("reached_halt", halted, 1'b1);
    endtask

    initial begin
        model_reset();
        prev_pc = 4'h0; saw3 = 1'b0; saw_wrap = 1'b0;
        fill(8'h80);
        @(negedge clk);

        // Program {ADD, HALT}
        mem[0] = 8'h25; mem[1] = 8'hF0;
        do_reset();
        run = 1'b1;
        repeat (3) tick();
        chk("t1_ir", {opcode, operand}, 8'h25);
        chk("t1_reg_we", reg_we, 1'b1);
        chk("t1_alu", alu_ctrl, 3'b000);
        tick();
        chk("t1_pc", pc, 4'h1);
        chk("t1_reg_we_drop", reg_we, 1'b0);
        run_until_halt(20);
        repeat (5) tick();
`ifdef FETCH_CTRL_INSTR_COUNT_EN
        chk("t1_count", instr_count, 8'd2);
`endif

        // STORE, NOP, JMP 0xA; address 3 must never be fetched
        fill(8'h80);
        mem[0] = 8'h13; mem[2] = 8'h7A; mem[3] = 8'h00; mem[10] = 8'hF0;
        do_reset();
        saw3 = 1'b0;
        run = 1'b1;
        repeat (3) tick();
        chk("store_mem_we", mem_we, 1'b1);
        chk("store_operand", operand, 4'h3);
        chk("store_reg_we", reg_we, 1'b0);
        repeat (6) tick();
        chk("jmp_exec_pc", pc, 4'h2);
        tick();
        chk("jmp_target", imem_addr, 4'hA);
        run_until_halt(20);
        chk("no_fetch_addr3", saw3, 1'b0);

        // Wrap over 16 NOPs
        fill(8'h80);
        do_reset();
        saw_wrap = 1'b0; prev_pc = 4'h0;
        run = 1'b1;
        repeat (60) tick();
        chk("pc_wrap", saw_wrap, 1'b1);

        // run dropped during DECODE of an ADD
        fill(8'h80);
        mem[0] = 8'h25;
        do_reset();
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        tick();
        chk("drop_reg_we", reg_we, 1'b1);
        repeat (4) tick();
        chk("drop_idle_pc", pc, 4'h1);
        run = 1'b1;
        repeat (3) tick();
        chk("resume_opcode", opcode, 4'h8);

        // Reset during EXECUTE of a LOAD
        fill(8'h80);
        mem[0] = 8'h00;
        do_reset();
        run = 1'b1;
        repeat (3) tick();
        chk("load_reg_we", reg_we, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_mid_reg_we", reg_we, 1'b0);
        chk("rst_mid_pc", pc, 4'h0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_idle_pc", pc, 4'h0);

        // Long NOP stream for counter saturation
        fill(8'h80);
        do_reset();
        run = 1'b1;
        repeat (800) tick();

        // Random programs and run patterns
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
            do_reset();
            for (int c = 0; c < 90; c++) begin
                run = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
